// File: rtl/descrambler_ctrl.sv
// descrambler_ctrl
// Per-beat control for the RX descrambler. Decodes the received symbols
// (8b/10b K-codes or 128b/130b block headers) and produces registered
// LFSR advance enables, LFSR reseed and per-byte bypass flags, plus a
// one-cycle framing error pulse. lfsr_sel is a constant derived from BYTES.
// BYTES must be one of 1, 2, 4, 8, 16.

module descrambler_ctrl #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               turn_off,
  input  logic               gen3_mode,
  input  logic               data_valid,
  input  logic [8*BYTES-1:0] pipe_data,
  input  logic [BYTES-1:0]   pipe_datak,
  input  logic               block_start,
  input  logic [1:0]         sync_header,
  output logic               pattern_reset,
  output logic [BYTES-1:0]   advance,
  output logic [BYTES-1:0]   bypass,
  output logic [2:0]         lfsr_sel,
  output logic               sync_err
);

  // 8b/10b control symbols
  localparam logic [7:0] K_COM    = 8'hBC;
  localparam logic [7:0] K_SKP    = 8'h1C;
  // 128b/130b ordered-set identifiers (first symbol of the block)
  localparam logic [7:0] OS_SKP   = 8'hAA;
  localparam logic [7:0] OS_EIEOS = 8'h00;

  // Bytes added to the block counter per valid beat; 16 wraps to 0, so a
  // 16-byte beat always sits on a block boundary.
  localparam logic [3:0] STEP     = 4'(BYTES % 16);
  localparam logic [2:0] LFSR_SEL = 3'($clog2(BYTES));

  typedef enum logic [2:0] {
    BT_NONE  = 3'd0,
    BT_DATA  = 3'd1,
    BT_OS    = 3'd2,
    BT_SKP   = 3'd3,
    BT_EIEOS = 3'd4,
    BT_BAD   = 3'd5
  } blk_type_e;

  // Block tracking state
  blk_type_e        blk_q, blk_d;
  logic [3:0]       cnt_q, cnt_d;

  // Registered outputs and their next values
  logic             pr_q, pr_d;
  logic [BYTES-1:0] adv_q, adv_d;
  logic [BYTES-1:0] byp_q, byp_d;
  logic             err_q, err_d;

  // Per-beat decode helpers
  logic [BYTES-1:0] is_com;
  logic [BYTES-1:0] is_skp;
  logic [7:0]       byte0;
  logic [3:0]       base_cnt;
  logic [3:0]       cnt_after;
  logic             beat_wrap;
  logic             frame_err;

  assign lfsr_sel = LFSR_SEL;
  assign byte0    = pipe_data[7:0];

  // A block_start beat is always the first beat of its block, so the
  // counter position for this beat restarts from zero.
  assign base_cnt  = block_start ? 4'd0 : cnt_q;
  assign cnt_after = base_cnt + STEP;
  assign beat_wrap = (cnt_after == 4'd0);

  // K-symbol detection per byte; plain data bytes with matching values are
  // not control symbols.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_kdec
      assign is_com[gi] = pipe_datak[gi] && (pipe_data[8*gi +: 8] == K_COM);
      assign is_skp[gi] = pipe_datak[gi] && (pipe_data[8*gi +: 8] == K_SKP);
    end
  endgenerate

  // State register: block type and byte position within the block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q <= BT_NONE;
      cnt_q <= 4'd0;
    end else begin
      blk_q <= blk_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state: block typing from sync header and framing checks
  always_comb begin
    blk_d     = blk_q;
    cnt_d     = cnt_q;
    frame_err = 1'b0;
    if (turn_off) begin
      blk_d = BT_NONE;
      cnt_d = 4'd0;
    end else if (data_valid && gen3_mode) begin
      if (block_start) begin
        // SKP ordered sets vary in length, so a new block arriving while a
        // SKP is in progress is not treated as misaligned.
        if ((cnt_q != 4'd0) && (blk_q != BT_SKP)) begin
          frame_err = 1'b1;
        end
        case (sync_header)
          2'b10: blk_d = BT_DATA;
          2'b01: begin
            if (byte0 == OS_SKP) begin
              blk_d = BT_SKP;
            end else if (byte0 == OS_EIEOS) begin
              blk_d = BT_EIEOS;
            end else begin
              blk_d = BT_OS;
            end
          end
          default: begin
            blk_d     = BT_BAD;
            frame_err = 1'b1;
          end
        endcase
      end else if ((cnt_q == 4'd0) && (blk_q != BT_SKP)) begin
        // A block boundary was reached but no header arrived. A SKP may
        // legitimately run past 16 bytes and keeps its type.
        blk_d     = BT_BAD;
        frame_err = 1'b1;
      end
      cnt_d = cnt_after;
    end
  end

  // Output decode: descrambler controls for the beat being sampled
  always_comb begin
    pr_d  = 1'b0;
    adv_d = '0;
    byp_d = '1;
    err_d = 1'b0;
    if (turn_off) begin
      pr_d  = 1'b1;
      adv_d = '1;
    end else if (data_valid) begin
      if (!gen3_mode) begin
        pr_d  = |is_com;
        adv_d = ~is_skp;
        byp_d = pipe_datak;
      end else begin
        err_d = frame_err;
        // The type decided on this beat (blk_d) governs this beat's outputs.
        case (blk_d)
          BT_DATA: begin
            adv_d = '1;
            byp_d = '0;
          end
          BT_OS: begin
            adv_d = '1;
          end
          BT_EIEOS: begin
            // Reseed once the full 16-byte EIEOS has been seen.
            pr_d = beat_wrap;
          end
          default: begin
            adv_d = '0;
          end
        endcase
      end
    end
  end

  // Output register: one-cycle latency from sampled beat to controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_q  <= 1'b1;
      adv_q <= '0;
      byp_q <= '1;
      err_q <= 1'b0;
    end else begin
      pr_q  <= pr_d;
      adv_q <= adv_d;
      byp_q <= byp_d;
      err_q <= err_d;
    end
  end

  assign pattern_reset = pr_q;
  assign advance       = adv_q;
  assign bypass        = byp_q;
  assign sync_err      = err_q;

endmodule
